// File: rtl/register_bank.sv
// Bank of NUM_REGS working registers with load/inc/dec/clr write port and combinational read.
// Define REGISTER_BANK_SATURATE_EN to clip inc/dec at the range limits instead of wrapping.
module register_bank #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              latch,
  input  logic              inc,
  input  logic              dec,
  input  logic              clr,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic [WIDTH-1:0]  data,
  input  logic [ADDR_W-1:0] rd_sel,
  output logic [WIDTH-1:0]  reg_out,
  output logic              zero,
  output logic              carry
);

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt_val;
  logic             nxt_carry;
  logic             wr_hit;
  logic             wr_en;

  // Select loops keep out-of-range selects from indexing past the array.
  always_comb begin
    cur     = '0;
    wr_hit  = 1'b0;
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (wr_sel == ADDR_W'(i)) begin
        cur    = regs[i];
        wr_hit = 1'b1;
      end
      if (rd_sel == ADDR_W'(i)) begin
        reg_out = regs[i];
      end
    end
  end

  always_comb begin
    nxt_val   = cur;
    nxt_carry = 1'b0;
    wr_en     = 1'b0;
    if (wr_hit) begin
      if (clr) begin
        wr_en   = 1'b1;
        nxt_val = '0;
      end else if (latch) begin
        wr_en   = 1'b1;
        nxt_val = data;
      end else if (inc && !dec) begin
        wr_en = 1'b1;
        if (cur == '1) begin
          nxt_carry = 1'b1;
`ifdef REGISTER_BANK_SATURATE_EN
          nxt_val   = '1;
`else
          nxt_val   = '0;
`endif
        end else begin
          nxt_val = cur + WIDTH'(1);
        end
      end else if (dec && !inc) begin
        wr_en = 1'b1;
        if (cur == '0) begin
          nxt_carry = 1'b1;
`ifdef REGISTER_BANK_SATURATE_EN
          nxt_val   = '0;
`else
          nxt_val   = '1;
`endif
        end else begin
          nxt_val = cur - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RST_V;
      end
      carry <= 1'b0;
    end else begin
      carry <= nxt_carry;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_en && wr_sel == ADDR_W'(i)) begin
          regs[i] <= nxt_val;
        end
      end
    end
  end

  assign zero = (reg_out == '0);

endmodule
